alu_cmd_issuer: RTL

//  Initiator side of the 5-bit ALU interface. Buffers operation requests arriving on a

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_cmd_issuer_if.sv | 47 ++++
 rtl/alu_cmd_fifo.sv | 60 ++++++
 rtl/alu_cmd_issuer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU command issuer: operand width, opcode encoding,
// the queued command record and a saturating counter helper.
package alu_pkg;

   localparam int ALU_W     = 5;
   localparam int CMD_TAG_W = 2;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_EQ  = 2'b01,
      OP_MUL = 2'b10,
      OP_ILL = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic [ALU_W-1:0]     a;
      logic [ALU_W-1:0]     b;
      alu_op_e              op;
      logic [CMD_TAG_W-1:0] tag;
   } alu_cmd_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      logic [CNT_W-1:0] res;
      if (cnt == {CNT_W{1'b1}}) begin
         res = cnt;
      end else begin
         res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundles the command, ALU and response channels of the issuer.
// master = the issuer itself, slave = the surrounding system (requester,
// combinational ALU and response consumer).
interface alu_cmd_issuer_if #(
   parameter int TAG_W = 2
);

   logic                        cmd_valid;
   logic                        cmd_ready;
   logic [alu_pkg::ALU_W-1:0]   cmd_a;
   logic [alu_pkg::ALU_W-1:0]   cmd_b;
   logic [1:0]                  cmd_op;
   logic [TAG_W-1:0]            cmd_tag;

   logic [alu_pkg::ALU_W-1:0]   alu_a;
   logic [alu_pkg::ALU_W-1:0]   alu_b;
   logic [1:0]                  alu_opcode;
   logic [alu_pkg::ALU_W-1:0]   alu_result;
   logic                        alu_overflow;
   logic                        alu_illegal;

   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [alu_pkg::ALU_W-1:0]   rsp_result;
   logic                        rsp_overflow;
   logic                        rsp_illegal;
   logic [TAG_W-1:0]            rsp_tag;

   modport master (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
      output cmd_ready,
      output alu_a, alu_b, alu_opcode,
      input  alu_result, alu_overflow, alu_illegal,
      output rsp_valid, rsp_result, rsp_overflow, rsp_illegal, rsp_tag,
      input  rsp_ready
   );

   modport slave (
      output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
      input  cmd_ready,
      input  alu_a, alu_b, alu_opcode,
      output alu_result, alu_overflow, alu_illegal,
      input  rsp_valid, rsp_result, rsp_overflow, rsp_illegal, rsp_tag,
      output rsp_ready
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra MSB so that full and
// empty are told apart without a separate occupancy counter. A push into a
// full FIFO is ignored even if a pop happens in the same cycle.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  alu_cmd_t wdata,
   input  logic     pop,
   output alu_cmd_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_r;
   logic [AW:0] rd_ptr_r;
   alu_cmd_t    mem_r [DEPTH];
   logic        do_push_s;
   logic        do_pop_s;

   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Advance write/read pointers on accepted push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

   // Storage array; cleared on reset so the empty-FIFO head is deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the 5-bit ALU interface. Commands are queued, the head
// command is presented to an external combinational ALU, and the ALU reply is
// captured into a response register together with the command tag. Saturating
// counters track responses flagged overflow and illegal.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = CMD_TAG_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_cmd_issuer_if.master     bus,
   output logic [CNT_W-1:0]     ovf_cnt,
   output logic [CNT_W-1:0]     ill_cnt
);

   alu_cmd_t          push_cmd_s;
   alu_cmd_t          head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              push_s;
   logic              issue_s;
   logic              rsp_ovf_next_s;

   logic              rsp_valid_r;
   logic [ALU_W-1:0]  rsp_result_r;
   logic              rsp_overflow_r;
   logic              rsp_illegal_r;
   logic [TAG_W-1:0]  rsp_tag_r;
   logic [CNT_W-1:0]  ovf_cnt_r;
   logic [CNT_W-1:0]  ill_cnt_r;

   // Pack the incoming command fields into one queue record.
   always_comb begin
      push_cmd_s     = '0;
      push_cmd_s.a   = bus.cmd_a;
      push_cmd_s.b   = bus.cmd_b;
      push_cmd_s.op  = alu_op_e'(bus.cmd_op);
      push_cmd_s.tag = bus.cmd_tag;
   end

   assign push_s = bus.cmd_valid & ~fifo_full_s;

   alu_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .wdata (push_cmd_s),
      .pop   (issue_s),
      .head  (head_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // A command may issue when one is queued and the response slot is free
   // or being drained in this very cycle.
   assign issue_s        = ~fifo_empty_s & (~rsp_valid_r | bus.rsp_ready);
   // An illegal op never reports overflow, whatever the ALU says.
   assign rsp_ovf_next_s = bus.alu_overflow & ~bus.alu_illegal;

   assign bus.cmd_ready  = ~fifo_full_s;

   // Drive the ALU from the FIFO head; an idle ALU sees add 0+0.
   always_comb begin
      bus.alu_a      = {ALU_W{1'b0}};
      bus.alu_b      = {ALU_W{1'b0}};
      bus.alu_opcode = OP_ADD;
      if (fifo_empty_s) begin
         bus.alu_a      = {ALU_W{1'b0}};
         bus.alu_b      = {ALU_W{1'b0}};
         bus.alu_opcode = OP_ADD;
      end else begin
         bus.alu_a      = head_s.a;
         bus.alu_b      = head_s.b;
         bus.alu_opcode = head_s.op;
      end
   end

   // Response register: capture on issue, clear valid on consumption, hold otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_r    <= 1'b0;
         rsp_result_r   <= {ALU_W{1'b0}};
         rsp_overflow_r <= 1'b0;
         rsp_illegal_r  <= 1'b0;
         rsp_tag_r      <= {TAG_W{1'b0}};
      end else if (issue_s) begin
         rsp_valid_r    <= 1'b1;
         rsp_result_r   <= bus.alu_result;
         rsp_overflow_r <= rsp_ovf_next_s;
         rsp_illegal_r  <= bus.alu_illegal;
         rsp_tag_r      <= head_s.tag;
      end else if (rsp_valid_r & bus.rsp_ready) begin
         rsp_valid_r    <= 1'b0;
      end
   end

   // Saturating event counters, stepped when a response is captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_r <= {CNT_W{1'b0}};
         ill_cnt_r <= {CNT_W{1'b0}};
      end else if (issue_s) begin
         if (rsp_ovf_next_s) begin
            ovf_cnt_r <= sat_inc(ovf_cnt_r);
         end
         if (bus.alu_illegal) begin
            ill_cnt_r <= sat_inc(ill_cnt_r);
         end
      end
   end

   assign bus.rsp_valid    = rsp_valid_r;
   assign bus.rsp_result   = rsp_result_r;
   assign bus.rsp_overflow = rsp_overflow_r;
   assign bus.rsp_illegal  = rsp_illegal_r;
   assign bus.rsp_tag      = rsp_tag_r;
   assign ovf_cnt          = ovf_cnt_r;
   assign ill_cnt          = ill_cnt_r;

endmodule
